// File: rtl/bus_mem_io.sv
// Memory + memory-mapped I/O slave for the CPU bus: byte RAM window,
// console TX register feeding a FIFO and 8N1 serialiser, status register
// and a sticky halt register. Reads are combinational (zero latency).
module bus_mem_io #(
  parameter int unsigned       ADDR_W     = 16,
  parameter int unsigned       MEM_WORDS  = 4096,
  parameter logic [ADDR_W-1:0] IO_BASE    = 16'hF000,
  parameter int unsigned       FIFO_DEPTH = 8,
  parameter int unsigned       BAUD_DIV   = 16,
  parameter logic [7:0]        HALT_CODE  = 8'hC0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              write_en,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic              tx,
  output logic              tx_strobe,
  output logic [7:0]        tx_byte,
  output logic              halted
);

  localparam int unsigned MEM_AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  localparam logic [ADDR_W:0]  MEM_LIM   = (ADDR_W+1)'(MEM_WORDS);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);

  localparam logic [7:0] OFF_TXDATA = 8'h10;
  localparam logic [7:0] OFF_STATUS = 8'h11;
  localparam logic [7:0] OFF_HALT   = 8'h20;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } ser_state_e;

  // Storage
  logic [7:0] mem [MEM_WORDS];
  logic [7:0] fifo_mem [FIFO_DEPTH];

  // Registers
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              tx_strobe_q, tx_strobe_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              halted_q, halted_d;
  ser_state_e        state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;

  // Decode / status
  logic       ram_hit;
  logic       io_hit;
  logic [7:0] io_off;
  logic       push_req;
  logic       push_ok;
  logic       pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic       tx_busy;
  logic       status_wr;
  logic       halt_wr;
  logic [7:0] tx_char;
  logic [7:0] status_val;

  // Address decode and FIFO handshake terms
  always_comb begin
    ram_hit    = ({1'b0, address} < MEM_LIM);
    io_hit     = (address[ADDR_W-1:8] == IO_BASE[ADDR_W-1:8]);
    io_off     = address[7:0];
    push_req   = write_en && io_hit && (io_off == OFF_TXDATA);
    status_wr  = write_en && io_hit && (io_off == OFF_STATUS);
    halt_wr    = write_en && io_hit && (io_off == OFF_HALT);
    tx_char    = data_in & 8'h7f;
    fifo_full  = (count_q == CNT_FULL);
    fifo_empty = (count_q == '0);
    pop        = (state_q == S_IDLE) && !fifo_empty;
    // A pop on the same edge frees the slot the push lands in, so a full FIFO still accepts.
    push_ok    = push_req && (!fifo_full || pop);
    tx_busy    = (state_q != S_IDLE) || !fifo_empty;
    status_val = {4'b0000, overflow_q, tx_busy, fifo_full, fifo_empty};
  end

  // Combinational read port; writes always read back zero
  always_comb begin
    data_out = '0;
    if (!write_en) begin
      if (ram_hit) begin
        data_out = mem[address[MEM_AW-1:0]];
      end else if (io_hit) begin
        case (io_off)
          OFF_STATUS: data_out = status_val;
          OFF_HALT:   data_out = {7'b0000000, halted_q};
          default:    data_out = '0;
        endcase
      end
    end
  end

  // FIFO pointers/count, overflow, strobe and halt next state
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    tx_strobe_d = push_ok;
    tx_byte_d   = tx_byte_q;
    halted_d    = halted_q;

    if (push_ok) begin
      wr_ptr_d  = wr_ptr_q + PTR_W'(1);
      tx_byte_d = tx_char;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (push_req && !push_ok) begin
      overflow_d = 1'b1;
    end else if (status_wr) begin
      overflow_d = 1'b0;
    end

    if (halt_wr && (data_in == HALT_CODE)) begin
      halted_d = 1'b1;
    end
  end

  // Serialiser next state: start bit, 8 data bits LSB first, stop bit
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        tx_d   = 1'b1;
        if (pop) begin
          shift_d = fifo_mem[rd_ptr_q];
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // RAM write port; contents survive reset
  always_ff @(posedge clock) begin
    if (write_en && ram_hit) begin
      mem[address[MEM_AW-1:0]] <= data_in;
    end
  end

  // FIFO storage write port
  always_ff @(posedge clock) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_q] <= tx_char;
    end
  end

  // Control and serialiser state registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      tx_strobe_q <= 1'b0;
      tx_byte_q   <= '0;
      halted_q    <= 1'b0;
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      tx_q        <= 1'b1;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      tx_strobe_q <= tx_strobe_d;
      tx_byte_q   <= tx_byte_d;
      halted_q    <= halted_d;
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
    end
  end

  assign tx        = tx_q;
  assign tx_strobe = tx_strobe_q;
  assign tx_byte   = tx_byte_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_bus_mem_io.sv
// Directed bench for bus_mem_io: RAM window, TX frame, FIFO overflow,
// full-FIFO push on pop edge, halt register and reset mid-frame.
module tb_bus_mem_io;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] address = '0;
  logic        write_en = 1'b0;
  logic [7:0]  data_in = '0;
  logic [7:0]  data_out;
  logic        tx;
  logic        tx_strobe;
  logic [7:0]  tx_byte;
  logic        halted;

  int n_checks = 0;
  int n_fail   = 0;
  int strobe_cnt = 0;
  logic [7:0] rx_q[$];
  logic [7:0] strobe_q[$];

  bus_mem_io #(
    .ADDR_W(16), .MEM_WORDS(4096), .IO_BASE(16'hF000),
    .FIFO_DEPTH(8), .BAUD_DIV(16), .HALT_CODE(8'hC0)
  ) dut (
    .clock(clock), .reset(reset), .address(address), .write_en(write_en),
    .data_in(data_in), .data_out(data_out), .tx(tx), .tx_strobe(tx_strobe),
    .tx_byte(tx_byte), .halted(halted)
  );

  always #5 clock = ~clock;

  // Strobe monitor
  always @(negedge clock) begin
    if (!reset && tx_strobe === 1'b1) begin
      strobe_cnt++;
      strobe_q.push_back(tx_byte);
    end
  end

  // Serial receiver: samples the middle of each 16-clock bit cell
  initial begin
    logic [7:0] b;
    b = '0;
    forever begin
      @(negedge clock);
      if (!reset && tx === 1'b0) begin
        repeat (7) @(negedge clock);
        if (tx === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (16) @(negedge clock);
            b[i] = tx;
          end
          repeat (16) @(negedge clock);
          rx_q.push_back(b);
        end
      end
    end
  end

  // Global time limit
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clock);
    address  = a;
    data_in  = d;
    write_en = 1'b1;
    @(posedge clock);
    #1;
    write_en = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
    @(negedge clock);
    address  = a;
    write_en = 1'b0;
    #1;
    d = data_out;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k;
    k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(posedge clock);
      k++;
    end
    n_checks++;
    if (rx_q.size() != n) begin
      n_fail++;
      $display("FAIL rx_count: got %0d bytes, expected %0d", rx_q.size(), n);
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    #2 reset = 1'b1;
    repeat (2) @(negedge clock);
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b, expected 1", tx); end
    n_checks++;
    if (tx_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_strobe: got %b, expected 0", tx_strobe); end
    n_checks++;
    if (tx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_tx_byte: got %h, expected 00", tx_byte); end
    n_checks++;
    if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b, expected 0", halted); end
    bus_read(16'hF011, d);
    n_checks++;
    if (d !== 8'h01) begin n_fail++; $display("FAIL reset_status: got %h, expected 01", d); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_ram();
    logic [7:0] d;
    bus_write(16'h0123, 8'h5A);
    bus_read(16'h0123, d);
    n_checks++;
    if (d !== 8'h5A) begin n_fail++; $display("FAIL ram_0123: got %h, expected 5a", d); end
    bus_write(16'h0FFF, 8'hA5);
    bus_read(16'h0FFF, d);
    n_checks++;
    if (d !== 8'hA5) begin n_fail++; $display("FAIL ram_top: got %h, expected a5", d); end
    bus_read(16'h0123, d);
    n_checks++;
    if (d !== 8'h5A) begin n_fail++; $display("FAIL ram_keep: got %h, expected 5a", d); end
    bus_write(16'h2000, 8'h77);
    bus_read(16'h2000, d);
    n_checks++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL unmapped_read: got %h, expected 00", d); end
    // read while writing the same value
    @(negedge clock);
    address = 16'h0123; data_in = 8'h5A; write_en = 1'b1;
    #1;
    n_checks++;
    if (data_out !== 8'h00) begin n_fail++; $display("FAIL read_during_write: got %h, expected 00", data_out); end
    @(posedge clock);
    #1 write_en = 1'b0;
    bus_read(16'hF030, d);
    n_checks++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL io_other: got %h, expected 00", d); end
    bus_read(16'hF010, d);
    n_checks++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL txdata_read: got %h, expected 00", d); end
    bus_read(16'hF020, d);
    n_checks++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL halt_read_idle: got %h, expected 00", d); end
  endtask

  task automatic test_tx_frame();
    logic [9:0] frame;
    logic [7:0] d;
    int errs;
    frame = {1'b1, 8'h41, 1'b0};
    rx_q.delete();
    bus_write(16'hF010, 8'hC1);
    n_checks++;
    if (tx_strobe !== 1'b1) begin n_fail++; $display("FAIL strobe: got %b, expected 1", tx_strobe); end
    n_checks++;
    if (tx_byte !== 8'h41) begin n_fail++; $display("FAIL tx_byte: got %h, expected 41", tx_byte); end
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL tx_before_start: got %b, expected 1", tx); end
    for (int b = 0; b < 10; b++) begin
      errs = 0;
      for (int c = 0; c < 16; c++) begin
        @(posedge clock);
        #1;
        if (tx !== frame[b]) errs++;
        if (b == 0 && c == 0) begin
          n_checks++;
          if (tx_strobe !== 1'b0) begin n_fail++; $display("FAIL strobe_width: got %b, expected 0", tx_strobe); end
        end
      end
      n_checks++;
      if (errs != 0) begin n_fail++; $display("FAIL frame_bit%0d: %0d cycles wrong, expected level %b", b, errs, frame[b]); end
    end
    @(posedge clock);
    #1;
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL tx_idle: got %b, expected 1", tx); end
    bus_read(16'hF011, d);
    n_checks++;
    if (d !== 8'h01) begin n_fail++; $display("FAIL status_after_frame: got %h, expected 01", d); end
    wait_rx(1, 20);
    if (rx_q.size() >= 1) begin
      n_checks++;
      if (rx_q[0] !== 8'h41) begin n_fail++; $display("FAIL rx_frame: got %h, expected 41", rx_q[0]); end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    int s0;
    rx_q.delete();
    strobe_q.delete();
    s0 = strobe_cnt;
    for (int i = 0; i < 10; i++) bus_write(16'hF010, 8'(8'h30 + i));
    bus_read(16'hF011, d);
    n_checks++;
    if (strobe_cnt - s0 != 9) begin n_fail++; $display("FAIL ovf_strobes: got %0d, expected 9", strobe_cnt - s0); end
    n_checks++;
    if (d !== 8'h0E) begin n_fail++; $display("FAIL ovf_status: got %h, expected 0e", d); end
    bus_write(16'hF011, 8'hFF);
    bus_read(16'hF011, d);
    n_checks++;
    if (d !== 8'h06) begin n_fail++; $display("FAIL ovf_clear: got %h, expected 06", d); end
    for (int i = 0; i < 9 && i < strobe_q.size(); i++) begin
      n_checks++;
      if (strobe_q[i] !== 8'(8'h30 + i)) begin n_fail++; $display("FAIL ovf_strobe_byte%0d: got %h, expected %h", i, strobe_q[i], 8'(8'h30 + i)); end
    end
    wait_rx(9, 9 * 161 + 300);
    for (int i = 0; i < 9 && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== 8'(8'h30 + i)) begin n_fail++; $display("FAIL ovf_rx%0d: got %h, expected %h", i, rx_q[i], 8'(8'h30 + i)); end
    end
    repeat (20) @(posedge clock);
  endtask

  task automatic test_full_pop();
    logic [7:0] d;
    rx_q.delete();
    for (int i = 0; i < 9; i++) bus_write(16'hF010, 8'(8'h50 + i));
    bus_read(16'hF011, d);
    n_checks++;
    if (d !== 8'h06) begin n_fail++; $display("FAIL full_status: got %h, expected 06", d); end
    // next edge after these is the one where the first frame ends and the serialiser pops
    repeat (153) @(posedge clock);
    bus_write(16'hF010, 8'h5F);
    n_checks++;
    if (tx_strobe !== 1'b1 || tx_byte !== 8'h5F) begin
      n_fail++; $display("FAIL full_pop_accept: strobe %b byte %h, expected 1 5f", tx_strobe, tx_byte);
    end
    bus_read(16'hF011, d);
    n_checks++;
    if (d !== 8'h06) begin n_fail++; $display("FAIL full_pop_status: got %h, expected 06", d); end
    wait_rx(10, 10 * 161 + 300);
    for (int i = 0; i < 10 && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== ((i < 9) ? 8'(8'h50 + i) : 8'h5F)) begin
        n_fail++; $display("FAIL full_pop_rx%0d: got %h", i, rx_q[i]);
      end
    end
    repeat (20) @(posedge clock);
  endtask

  task automatic test_halt();
    logic [7:0] d;
    do_reset();
    bus_write(16'hF020, 8'hC1);
    n_checks++;
    if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_wrong_code: got %b, expected 0", halted); end
    bus_write(16'hF021, 8'hC0);
    n_checks++;
    if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_wrong_addr: got %b, expected 0", halted); end
    bus_write(16'hF020, 8'hC0);
    n_checks++;
    if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_set: got %b, expected 1", halted); end
    bus_read(16'hF020, d);
    n_checks++;
    if (d !== 8'h01) begin n_fail++; $display("FAIL halt_read: got %h, expected 01", d); end
    bus_write(16'hF020, 8'h00);
    repeat (5) @(posedge clock);
    #1;
    n_checks++;
    if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_sticky: got %b, expected 1", halted); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    int errs;
    do_reset();
    bus_write(16'hF010, 8'h55);
    bus_write(16'hF010, 8'h66);
    bus_write(16'hF010, 8'h77);
    // now 1 clock into the start bit; advance into the middle of data bit 3
    repeat (70) @(posedge clock);
    #1;
    n_checks++;
    if (tx !== 1'b0) begin n_fail++; $display("FAIL mid_bit3: got %b, expected 0", tx); end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL async_reset_tx: got %b, expected 1", tx); end
    bus_read(16'hF011, d);
    n_checks++;
    if (d !== 8'h01) begin n_fail++; $display("FAIL mid_reset_status: got %h, expected 01", d); end
    @(negedge clock);
    reset = 1'b0;
    bus_read(16'h0123, d);
    n_checks++;
    if (d !== 8'h5A) begin n_fail++; $display("FAIL ram_after_reset: got %h, expected 5a", d); end
    errs = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clock);
      #1;
      if (tx !== 1'b1) errs++;
    end
    n_checks++;
    if (errs != 0) begin n_fail++; $display("FAIL discard_fifo: tx low %0d cycles, expected 0", errs); end
    bus_read(16'hF011, d);
    n_checks++;
    if (d !== 8'h01) begin n_fail++; $display("FAIL post_reset_status: got %h, expected 01", d); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_tx_frame();
    test_overflow();
    test_full_pop();
    test_halt();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
